// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync marker, MSB-first payload, optional even-parity bit.
// Optional parity stage is enabled by defining SYNC_FRAME_TX_PARITY_EN.
module sync_frame_tx #(
  parameter int unsigned          DATA_WIDTH   = 8,
  parameter int unsigned          SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0]  SYNC_PATTERN = 4'b1101
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  bit_en,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  serial_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned FrameW = SYNC_LEN + DATA_WIDTH;
  localparam int unsigned MaxLen = (SYNC_LEN > DATA_WIDTH) ? SYNC_LEN : DATA_WIDTH;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam logic [CntW-1:0] SyncLast = CntW'(SYNC_LEN - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

`ifdef SYNC_FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {StIdle, StSync, StData, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSync, StData} state_e;
`endif

  state_e              state_q, state_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                serial_q, serial_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // Marker and payload share one shift register; its MSB is always the bit on the line.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
`ifdef SYNC_FRAME_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          frame_d = {SYNC_PATTERN, tx_data};
          cnt_d   = '0;
          state_d = StSync;
`ifdef SYNC_FRAME_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      StSync: begin
        if (bit_en) begin
          frame_d = {frame_q[FrameW-2:0], 1'b0};
          if (cnt_q == SyncLast) begin
            cnt_d   = '0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (bit_en) begin
          frame_d = {frame_q[FrameW-2:0], 1'b0};
          if (cnt_q == DataLast) begin
            cnt_d = '0;
`ifdef SYNC_FRAME_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StIdle;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
`ifdef SYNC_FRAME_TX_PARITY_EN
      StParity: begin
        if (bit_en) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they appear registered with no extra lag.
  always_comb begin
    serial_d = 1'b0;
    busy_d   = (state_d != StIdle);
    done_d   = (state_q != StIdle) && (state_d == StIdle);
    case (state_d)
      StSync, StData: serial_d = frame_d[FrameW-1];
`ifdef SYNC_FRAME_TX_PARITY_EN
      StParity:       serial_d = parity_d;
`endif
      default:        serial_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      frame_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Scoreboard bench for sync_frame_tx: stimulus pushes expected bits, a monitor pops and compares.
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       bit_en;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       serial_out;
  logic       tx_busy;
  logic       tx_done;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb[$];
  logic exp_done = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  sync_frame_tx dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bit_en     (bit_en),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed frame (1101 + payload) plus its even-parity bit.
  task automatic push_frame(input logic [11:0] bits, input logic par);
    exp_t e;
`ifdef SYNC_FRAME_TX_PARITY_EN
    for (int i = 11; i >= 0; i--) begin
      e.b = bits[i]; e.last = 1'b0; sb.push_back(e);
    end
    e.b = par; e.last = 1'b1; sb.push_back(e);
`else
    for (int i = 11; i >= 0; i--) begin
      e.b = bits[i]; e.last = (i == 0); sb.push_back(e);
    end
    e.b = par;
`endif
  endtask

  task automatic send(input logic [7:0] d, input logic [11:0] bits, input logic par);
    tx_start = 1'b1;
    tx_data  = d;
    push_frame(bits, par);
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every cycle the DUT is busy; pops on cycles whose edge samples bit_en.
  always @(negedge clk) begin
    if (!n_rst) begin
      check("rst_serial", serial_out, 0);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      exp_done = 1'b0;
    end else begin
      check("done", tx_done, exp_done);
      exp_done = 1'b0;
      if (tx_busy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL busy_unexpected: got busy=1, expected idle at %0t", $time);
        end else begin
          check("bit", serial_out, sb[0].b);
          if (bit_en) begin
            exp_done = sb[0].last;
            void'(sb.pop_front());
          end
        end
      end else begin
        check("idle_serial", serial_out, 0);
      end
    end
  end

  initial begin
    bool_init();
  end

  task automatic bool_init();
    logic seen;
    n_rst    = 1'b0;
    bit_en   = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    repeat (4) @(posedge clk);
    #1;
    tx_start = 1'b0;
    n_rst    = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 0xA5, continuous bit_en
    send(8'hA5, 12'b1101_1010_0101, 1'b0);
    wait_drain();

    // 0x07: parity bit 1
    send(8'h07, 12'b1101_0000_0111, 1'b1);
    wait_drain();

    // 0xFF with bit_en every 3rd cycle; mid-frame request with 0x00 must be ignored
    bit_en   = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    push_frame(12'b1101_1111_1111, 1'b0);
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      tx_start = (i == 10);
      if (i == 10) tx_data = 8'h00;
      bit_en = (i % 3 == 0);
    end
    tx_start = 1'b0;
    bit_en   = 1'b1;
    wait_drain();

    // Back-to-back: request 0x3C in the tx_done cycle
    send(8'hA5, 12'b1101_1010_0101, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    push_frame(12'b1101_0011_1100, 1'b0);
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("b2b_busy", tx_busy, 1);
    check("b2b_first", serial_out, 1);
    wait_drain();

    // Reset during the 5th data bit aborts with no tx_done
    send(8'hA5, 12'b1101_1010_0101, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    n_rst = 1'b0;
    sb.delete();
    #1;
    check("abort_serial", serial_out, 0);
    check("abort_busy", tx_busy, 0);
    check("abort_done", tx_done, 0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_abort_busy", tx_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

endmodule

// File: doc/sync_frame_tx.md
# sync_frame_tx

Serial frame transmitter that produces the bit stream the team's Moore sync detector consumes. On request it emits a fixed sync marker (1101 by default), then a latched payload word MSB-first, optionally followed by an even-parity bit. It sits on the transmit side of the serial link, driven by a control FSM and paced by a bit-rate strobe.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1)
- SYNC_LEN, 4, sync marker length in bits (≥1)
- SYNC_PATTERN, 4'b1101, sync marker, SYNC_LEN bits, sent MSB first
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- bit_en  input  1  bit-rate strobe; the current bit advances on cycles where it is 1
- tx_start  input  1  frame request; sampled only when idle
- tx_data  input  DATA_WIDTH  payload; captured in the tx_start accept cycle
- serial_out  output  1  serial line, registered; idle level 0
- tx_busy  output  1  high from the cycle after accept through the last bit of the frame
- tx_done  output  1  one-cycle pulse in the first idle cycle after a frame

## Operation
- One clock, one asynchronous active-low reset.
- States: IDLE, SYNC, DATA, PARITY (PARITY exists only with the macro).
- IDLE: serial_out=0, tx_busy=0. If tx_start=1, latch tx_data into the shift register, load bit counter, and go to SYNC.
- SYNC: serial_out = SYNC_PATTERN[SYNC_LEN-1-k] for bit k. On bit_en, k increments. After bit SYNC_LEN-1 is consumed, go to DATA.
- DATA: serial_out = payload bit DATA_WIDTH-1-j, MSB first. On bit_en, shift. After the last bit, go to PARITY if enabled, else IDLE.
- PARITY: serial_out = XOR of the latched payload (even parity). On bit_en, go to IDLE.
- Return to IDLE: tx_done=1 for exactly that one cycle.
- tx_start while busy: ignored. There is no queuing.
- tx_data changing mid-frame has no effect.
- Bit counter is $clog2(max(SYNC_LEN, DATA_WIDTH)+1) bits and is reset per phase.
- Payload bits that happen to match the marker are not escaped; framing above this block handles that.

## Timing
- Reset values: serial_out=0, tx_busy=0, tx_done=0, state=IDLE, shift register=0, counter=0.
- Reset asserted mid-frame aborts immediately. No tx_done is produced for the aborted frame.
- Latency: tx_start sampled at edge N. First sync bit appears on serial_out and tx_busy=1 from edge N+1.
- Each bit is held until the edge that samples bit_en=1, then the next bit appears after that edge.
- With bit_en tied to 1, a frame occupies SYNC_LEN+DATA_WIDTH(+1) consecutive busy cycles.
- tx_done pulse cycle is IDLE, so tx_start asserted in that cycle is accepted. Back-to-back frames are separated by exactly one idle cycle at serial_out=0.
- All outputs are driven from flops; there are no combinational input-to-output paths.

## Configuration
- SYNC_FRAME_TX_PARITY_EN defined: PARITY state present; one even-parity bit is appended after the payload; frame length is SYNC_LEN+DATA_WIDTH+1.
- Not defined: no PARITY state; DATA goes straight to IDLE; frame length is SYNC_LEN+DATA_WIDTH.

## Test plan
- Reset: hold n_rst=0 with tx_start=1 -> serial_out=0, tx_busy=0, tx_done=0 throughout. Release reset -> frame starts only after tx_start is sampled.
- No parity, bit_en=1, tx_data=8'hA5: serial_out = 1,1,0,1,1,0,1,0,0,1,0,1 on 12 consecutive cycles, tx_busy high for those 12 cycles, tx_done pulses on cycle 13.
- Parity enabled, tx_data=8'h07: stream = 1101 00000111 then 1, for 13 busy cycles. With tx_data=8'hA5 the final bit is 0.
- bit_en asserted every 3rd cycle, tx_data=8'hFF: each bit is held 3 cycles. Pulse tx_start mid-frame with tx_data=8'h00 -> ignored, the frame completes as 0xFF.
- tx_start asserted in the tx_done cycle with new data 8'h3C: the second frame's first sync bit appears after exactly one idle cycle at 0.
- Assert n_rst=0 during the 5th data bit -> outputs are 0 immediately. After release, the line stays idle until a new tx_start, and no tx_done is produced for the aborted frame.
